// File: rtl/tick_divider_bank_pkg.sv
// tick_pkg: shared definitions for the tick divider bank.
// Holds the channel mode encodings, the divisor every channel wakes up with,
// and a record type that describes the complete state of one channel.
// No ports; imported by the channel and top-level modules.
package tick_pkg;

    // Mode bit written alongside each divisor.
    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Natural counter width, wide enough to divide CLOCK_50 down to below 1 Hz.
    localparam int TICK_WIDTH = 28;

    // Divisor loaded into every channel while reset is asserted.
    localparam int TICK_DEFAULT_DIV = 2;

    // Everything a channel remembers between clock edges.
    typedef struct packed {
        logic [TICK_WIDTH-1:0] divisor;
        logic [TICK_WIDTH-1:0] counter;
        logic                  mode;
        logic                  armed;
    } ch_state_t;

endpackage

// File: rtl/tick_divider_bank_if.sv
// tick_divider_bank_if: control and status bundle of the tick divider bank.
//   wr_en/wr_chan/wr_data/wr_mode : program one channel's divisor and mode
//   ch_enable                     : per-channel run enable
//   sync_clear                    : restart every channel's period together
//   tick/square/busy              : per-channel status returned by the bank
// The master modport belongs to whoever programs the bank; the slave modport
// belongs to the bank itself.
interface tick_divider_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 28,
    parameter int CH_W   = 2
);

    logic              wr_en;
    logic [CH_W-1:0]   wr_chan;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_mode;
    logic [NUM_CH-1:0] ch_enable;
    logic              sync_clear;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;
    logic [NUM_CH-1:0] busy;

    modport master (
        output wr_en, wr_chan, wr_data, wr_mode, ch_enable, sync_clear,
        input  tick, square, busy
    );

    modport slave (
        input  wr_en, wr_chan, wr_data, wr_mode, ch_enable, sync_clear,
        output tick, square, busy
    );

endinterface

// File: rtl/tick_divider_bank_channel.sv
// tick_channel: one programmable divider channel.
// Ports:
//   clock, resetn : system clock, asynchronous active-low reset
//   wr            : write strobe already decoded for this channel
//   wr_data       : new divisor (0 stalls the channel)
//   wr_mode       : MODE_FREE or MODE_ONESHOT
//   enable        : run enable; low freezes the count
//   sync_clear    : restart the period and re-arm a one-shot
//   tick          : registered one-cycle pulse on the period wrap
//   square        : registered ~50% duty square wave
//   busy          : channel is currently counting
module tick_channel
    import tick_pkg::*;
#(
    parameter int WIDTH   = TICK_WIDTH,
    parameter int DEF_DIV = TICK_DEFAULT_DIV
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_mode,
    input  logic             enable,
    input  logic             sync_clear,
    output logic             tick,
    output logic             square,
    output logic             busy
);

    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] counter;
    logic             mode;
    logic             armed;
    logic             tick_q;
    logic             square_q;

    logic active;
    logic stalled;
    logic at_end;
    logic half_reached;

    // A one-shot that has already fired is inactive until re-armed; a zero
    // divisor stalls the channel. at_end is only meaningful when not stalled,
    // which keeps the wrapped value of divisor-1 from ever being used.
    always_comb begin
        active       = (mode == MODE_FREE) || armed;
        stalled      = (divisor == '0);
        at_end       = (counter == (divisor - WIDTH'(1)));
        half_reached = (counter >= (divisor >> 1));
    end

    // Channel registers. A write restarts the channel with its new settings
    // and beats both sync_clear and a coincident wrap, so no tick escapes on
    // the write edge. The square wave is computed from the count before the
    // edge, which places its high half in the later part of each period.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            divisor  <= WIDTH'(DEF_DIV);
            counter  <= '0;
            mode     <= MODE_FREE;
            armed    <= 1'b1;
            tick_q   <= 1'b0;
            square_q <= 1'b0;
        end else if (wr) begin
            divisor  <= wr_data;
            mode     <= wr_mode;
            counter  <= '0;
            armed    <= 1'b1;
            tick_q   <= 1'b0;
            square_q <= 1'b0;
        end else if (sync_clear) begin
            counter  <= '0;
            armed    <= 1'b1;
            tick_q   <= 1'b0;
            square_q <= 1'b0;
        end else if (stalled || !active) begin
            counter  <= '0;
            tick_q   <= 1'b0;
            square_q <= 1'b0;
        end else if (!enable) begin
            tick_q   <= 1'b0;
        end else begin
            tick_q   <= at_end;
            square_q <= half_reached;
            counter  <= at_end ? '0 : counter + WIDTH'(1);
            if (at_end && (mode == MODE_ONESHOT)) begin
                armed <= 1'b0;
            end
        end
    end

    assign tick   = tick_q;
    assign square = square_q;
    assign busy   = active && enable && !stalled;

endmodule

// File: rtl/tick_divider_bank.sv
// tick_divider_bank: NUM_CH independent programmable clock-enable generators.
// Ports:
//   clock  : system clock (CLOCK_50 domain)
//   resetn : asynchronous active-low reset
//   bus    : slave side of tick_divider_bank_if (write port, enables,
//            sync_clear in; tick/square/busy out)
// Ticks are meant to be used as clock enables; the square waves are status
// only and must never clock other logic.
module tick_divider_bank
    import tick_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = TICK_WIDTH,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
    input  logic                 clock,
    input  logic                 resetn,
    tick_divider_bank_if.slave   bus
);

    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] square_v;
    logic [NUM_CH-1:0] busy_v;

    // Each channel gets its own write strobe. Indices at or above NUM_CH
    // match no channel, so writes aimed there are silently dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_wr;

        assign ch_wr = bus.wr_en && (bus.wr_chan == CH_W'(g));

        tick_channel #(
            .WIDTH   (WIDTH),
            .DEF_DIV (DEFAULT_DIV)
        ) u_channel (
            .clock      (clock),
            .resetn     (resetn),
            .wr         (ch_wr),
            .wr_data    (bus.wr_data),
            .wr_mode    (bus.wr_mode),
            .enable     (bus.ch_enable[g]),
            .sync_clear (bus.sync_clear),
            .tick       (tick_v[g]),
            .square     (square_v[g]),
            .busy       (busy_v[g])
        );
    end

    assign bus.tick   = tick_v;
    assign bus.square = square_v;
    assign bus.busy   = busy_v;

endmodule
